sram_uart_tx_interface: RTL

//  Streams a block of 16-bit SRAM words out of UART_TX_O as 8N1 serial bytes, high byte first.
//  It is the transmit-side counterpart of the UART receive path that loads images into SRAM.
//  It is used to dump results (e.g. decoded RGB data) back to the PC for checking.
//  The top level muxes its SRAM_address/SRAM_we_n onto the SRAM controller while Busy=1.

---
 rtl/sram_uart_tx_interface.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/sram_uart_tx_interface.sv
// Reads a block of 16-bit SRAM words and sends each word as two 8N1 UART frames,
// high byte first, on a registered serial line.
module sram_uart_tx_interface #(
  parameter int CLKS_PER_BIT      = 434,
  parameter int SRAM_READ_LATENCY = 2
) (
  input  logic        Clock_50,
  input  logic        Reset,
  input  logic        Start,
  input  logic [17:0] Start_address,
  input  logic [17:0] Word_count,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic        UART_TX_O,
  output logic        Busy,
  output logic        Done
);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int WAIT_W = (SRAM_READ_LATENCY > 1) ? $clog2(SRAM_READ_LATENCY) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SRAM_READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ_WAIT, S_START_BIT, S_DATA_BITS, S_STOP_BIT, S_NEXT_WORD
  } state_t;

  state_t              state_q, state_d;
  logic [17:0]         addr_q, addr_d;
  logic [17:0]         remaining_q, remaining_d;
  logic [7:0]          low_byte_q, low_byte_d;
  logic [7:0]          shift_q, shift_d;
  logic                byte_sel_q, byte_sel_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                baud_tick;

  // Start is a request pulse taken only in S_IDLE outside the Done cycle;
  // Busy covers the whole transfer and Done is a single-cycle completion strobe.
  assign SRAM_address = addr_q;
  assign SRAM_we_n    = 1'b1;
  assign UART_TX_O    = tx_q;
  assign Busy         = busy_q;
  assign Done         = done_q;
  assign baud_tick    = (baud_q == BAUD_LAST);

  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      low_byte_q  <= '0;
      shift_q     <= '0;
      byte_sel_q  <= 1'b0;
      bit_cnt_q   <= '0;
      baud_q      <= '0;
      wait_q      <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      low_byte_q  <= low_byte_d;
      shift_q     <= shift_d;
      byte_sel_q  <= byte_sel_d;
      bit_cnt_q   <= bit_cnt_d;
      baud_q      <= baud_d;
      wait_q      <= wait_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    low_byte_d  = low_byte_q;
    shift_d     = shift_q;
    byte_sel_d  = byte_sel_q;
    bit_cnt_d   = bit_cnt_q;
    baud_d      = baud_q;
    wait_d      = wait_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tx_d        = 1'b1;

    case (state_q)
      S_IDLE: begin
        // done_q still high means the previous transfer is finishing this cycle.
        if (Start && !done_q) begin
          if (Word_count != '0) begin
            addr_d      = Start_address;
            remaining_d = Word_count;
            busy_d      = 1'b1;
            wait_d      = '0;
            state_d     = S_READ_WAIT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_READ_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          low_byte_d = SRAM_read_data[7:0];
          shift_d    = SRAM_read_data[15:8];
          byte_sel_d = 1'b0;
          baud_d     = '0;
          state_d    = S_START_BIT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_START_BIT: begin
        if (baud_tick) begin
          baud_d    = '0;
          bit_cnt_d = '0;
          state_d   = S_DATA_BITS;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA_BITS: begin
        if (baud_tick) begin
          baud_d    = '0;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_STOP_BIT;
          else                   shift_d = {1'b0, shift_q[7:1]};
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP_BIT: begin
        if (baud_tick) begin
          baud_d = '0;
          if (!byte_sel_q) begin
            shift_d    = low_byte_q;
            byte_sel_d = 1'b1;
            state_d    = S_START_BIT;
          end else begin
            state_d = S_NEXT_WORD;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_NEXT_WORD: begin
        remaining_d = remaining_q - 18'd1;
        addr_d      = addr_q + 18'd1;
        wait_d      = '0;
        if (remaining_q == 18'd1) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_READ_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The line register follows the state being entered so it changes with the state.
    if (state_d == S_START_BIT)      tx_d = 1'b0;
    else if (state_d == S_DATA_BITS) tx_d = shift_d[0];
  end
endmodule
